serial_paralelo_verde: RTL and testbench

SERIAL_PARALELO_VERDE -- requirements
Module: serial_paralelo_verde

---
 rtl/serial_paralelo_verde_pkg.sv | 14 +
 rtl/serial_shift_align.sv | 45 ++++
 rtl/serial_paralelo_verde.sv | 119 +++++++++++
 tb/tb_serial_paralelo_verde.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_verde_pkg.sv
// Shared PHY definitions for the serial link: comma symbol, lock depth and aligner states.
// Used by both the parallel-to-serial and serial-to-parallel stages.
package serial_paralelo_verde_pkg;

    localparam logic [7:0]  COM_DEFAULT     = 8'hBC;
    localparam int unsigned BC_LOCK_DEFAULT = 4;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StAlign  = 2'd1,
        StActive = 2'd2
    } phy_state_e;

endpackage

// File: rtl/serial_shift_align.sv
// Serial input shifter with byte-phase counter and comma comparator.
// byte_o is the byte including the bit being sampled this cycle.
module serial_shift_align
    import serial_paralelo_verde_pkg::*;
#(
    parameter logic [7:0] COM = COM_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       data_i,
    input  logic       clr_cnt_i,
    input  logic       cnt_en_i,
    output logic [7:0] byte_o,
    output logic       com_match_o,
    output logic       boundary_o
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = {shift_q[6:0], data_i};
        cnt_d   = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = 3'd0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_o      = shift_d;
    assign com_match_o = (shift_d == COM);
    assign boundary_o  = (cnt_q == 3'd7);

endmodule

// File: rtl/serial_paralelo_verde.sv
// Serial-to-parallel receiver: comma alignment FSM, lock detection and registered byte output.
// Once locked the link stays active until reset.
module serial_paralelo_verde
    import serial_paralelo_verde_pkg::*;
#(
    parameter logic [7:0]  COM     = COM_DEFAULT,
    parameter int unsigned BC_LOCK = BC_LOCK_DEFAULT
) (
    input  logic       clk32_f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_tick
);

    localparam logic [3:0] BcLock = 4'(BC_LOCK);

    phy_state_e state_q, state_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       tick_q, tick_d;

    logic [7:0] cur_byte;
    logic       com_match;
    logic       boundary;
    logic       clr_cnt;
    logic       cnt_en;

    assign cnt_en = (state_q != StSearch);

    serial_shift_align #(
        .COM(COM)
    ) u_shift_align (
        .clk_i       (clk32_f),
        .rst_i       (reset),
        .data_i      (data_in),
        .clr_cnt_i   (clr_cnt),
        .cnt_en_i    (cnt_en),
        .byte_o      (cur_byte),
        .com_match_o (com_match),
        .boundary_o  (boundary)
    );

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        tick_d    = 1'b0;
        clr_cnt   = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (com_match) begin
                    clr_cnt   = 1'b1;
                    com_cnt_d = 4'd1;
                    if (BcLock == 4'd1) begin
                        state_d = StActive;
                        data_d  = cur_byte;
                        valid_d = 1'b0;
                    end else begin
                        state_d = StAlign;
                    end
                end
            end
            StAlign: begin
                if (boundary) begin
                    if (com_match) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        tick_d    = 1'b1;
                        if (com_cnt_q + 4'd1 == BcLock) begin
                            state_d = StActive;
                            data_d  = cur_byte;
                            valid_d = 1'b0;
                        end
                    end else begin
                        // A rejected byte drops straight back to search without a tick.
                        com_cnt_d = 4'd0;
                        state_d   = StSearch;
                    end
                end
            end
            StActive: begin
                if (boundary) begin
                    tick_d  = 1'b1;
                    data_d  = cur_byte;
                    valid_d = !com_match;
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk32_f or posedge reset) begin
        if (reset) begin
            state_q   <= StSearch;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            tick_q    <= tick_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign byte_tick = tick_q;
    assign active    = (state_q == StActive);

endmodule

// File: tb/tb_serial_paralelo_verde.sv
// Directed bench for the serial-to-parallel receiver with a bit-stream reference model
// compared against the DUT on every clock.
module tb_serial_paralelo_verde;

    localparam logic [7:0] M_COM  = 8'hBC;
    localparam int         M_LOCK = 4;

    logic       clk32_f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_tick;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference model: mode 0 = hunting, 1 = counting commas, 2 = locked.
    int         m_mode;
    int         m_since;
    int         m_coms;
    logic [7:0] m_win;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_active;
    logic       exp_tick;

    serial_paralelo_verde dut (
        .clk32_f   (clk32_f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .byte_tick (byte_tick)
    );

    always #5 clk32_f = ~clk32_f;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_since    = 0;
        m_coms     = 0;
        m_win      = 8'h00;
        exp_data   = 8'h00;
        exp_valid  = 1'b0;
        exp_active = 1'b0;
        exp_tick   = 1'b0;
    endtask

    task automatic model_step(input logic b);
        m_win    = {m_win[6:0], b};
        exp_tick = 1'b0;
        if (m_mode == 0) begin
            if (m_win == M_COM) begin
                m_coms  = 1;
                m_since = 0;
                m_mode  = (M_LOCK == 1) ? 2 : 1;
                if (m_mode == 2) begin
                    exp_data  = m_win;
                    exp_valid = 1'b0;
                end
            end
        end else begin
            m_since++;
            if (m_since == 8) begin
                m_since = 0;
                if (m_mode == 1) begin
                    if (m_win == M_COM) begin
                        m_coms++;
                        exp_tick = 1'b1;
                        if (m_coms == M_LOCK) begin
                            m_mode    = 2;
                            exp_data  = m_win;
                            exp_valid = 1'b0;
                        end
                    end else begin
                        m_mode = 0;
                        m_coms = 0;
                    end
                end else begin
                    exp_tick  = 1'b1;
                    exp_data  = m_win;
                    exp_valid = (m_win != M_COM);
                end
            end
        end
        exp_active = (m_mode == 2);
    endtask

    task automatic compare_all();
        check("data_out", 32'(data_out), 32'(exp_data));
        check("valid_out", 32'(valid_out), 32'(exp_valid));
        check("active", 32'(active), 32'(exp_active));
        check("byte_tick", 32'(byte_tick), 32'(exp_tick));
    endtask

    // Drive one bit, clock it in, then compare away from the active edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk32_f);
        model_step(b);
        @(negedge clk32_f);
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Assert reset between edges so the mid-cycle clearing is observable.
    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1;
        check("rst data_out", 32'(data_out), 32'h0);
        check("rst valid_out", 32'(valid_out), 32'h0);
        check("rst active", 32'(active), 32'h0);
        check("rst byte_tick", 32'(byte_tick), 32'h0);
        model_reset();
        @(posedge clk32_f);
        @(negedge clk32_f);
        reset = 1'b0;
    endtask

    logic [7:0] up_bytes [7];
    logic       up_valid [7];

    initial begin
        model_reset();
        @(negedge clk32_f);
        pulse_reset();

        // Lock on four commas.
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        for (int i = 7; i >= 1; i--) send_bit(M_COM[i]);
        check("pre-lock active", 32'(active), 32'h0);
        send_bit(1'b0);
        check("lock active", 32'(active), 32'h1);
        check("lock data", 32'(data_out), 32'hBC);
        check("lock valid", 32'(valid_out), 32'h0);
        check("lock tick", 32'(byte_tick), 32'h1);

        // Payload byte, held for a full byte period, then a comma clears valid.
        send_byte(8'hA5);
        check("a5 data", 32'(data_out), 32'hA5);
        check("a5 valid", 32'(valid_out), 32'h1);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("a5 held data", 32'(data_out), 32'hA5);
        check("a5 held tick", 32'(byte_tick), 32'h0);
        send_bit(1'b1);
        send_byte(8'hBC);
        check("bc after a5 valid", 32'(valid_out), 32'h0);
        check("bc after a5 data", 32'(data_out), 32'hBC);

        // Broken lock attempt followed by lock at a 3-bit offset.
        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h3C);
        check("3c active", 32'(active), 32'h0);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        check("offset lock active", 32'(active), 32'h1);
        send_byte(8'h5A);
        check("offset payload data", 32'(data_out), 32'h5A);
        check("offset payload valid", 32'(valid_out), 32'h1);

        // Reset mid-payload in ACTIVE; three commas are not enough to relock.
        send_byte(8'hA5);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        pulse_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        check("relock 3 active", 32'(active), 32'h0);
        send_byte(8'hBC);
        check("relock 4 active", 32'(active), 32'h1);

        // Upstream serializer behaviour: idle slots carry comma, valid slots carry payload.
        up_valid = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        up_bytes = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h33, 8'h00};
        for (int s = 0; s < 7; s++) begin
            send_byte(up_valid[s] ? up_bytes[s] : M_COM);
            check("ser valid", 32'(valid_out), 32'(up_valid[s]));
            check("ser data", 32'(data_out), up_valid[s] ? 32'(up_bytes[s]) : 32'hBC);
            check("ser tick", 32'(byte_tick), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
